// File: rtl/ssd_scan_if.sv
// Host-side bundle of the seven-segment scan controller: capture strobe,
// value and display options in, conversion status and anode/segment drive out.
interface ssd_scan_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32
);
    logic                  load;
    logic [DATA_W-1:0]     value;
    logic                  dec_mode;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  busy;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            ssdOut;
    logic                  dp;

    modport master (
        output load, value, dec_mode, dp_mask,
        input  busy, anode, ssdOut, dp
    );

    modport slave (
        input  load, value, dec_mode, dp_mask,
        output busy, anode, ssdOut, dp
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller with hex display and sequential double-dabble decimal.
// Optional macro SSD_LZ_BLANK_EN blanks leading zero digits (digit 0 always shown).
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic      clk,
    input  logic      rst,
    ssd_scan_if.slave bus
);
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          REF_W     = $clog2(REFRESH_DIV);
    localparam int          CNT_W     = $clog2(DATA_W + 1);
    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);
    localparam logic [6:0]  SEG_DASH  = 7'b1111110;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  accept_s, step_s, last_s;
    logic [DATA_W-1:0]     sh_q;
    logic [BCD_W-1:0]      bcd_q, bcd_next_s, val_ext_s, digit_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_DIGITS-1:0] dpm_q, dp_pend_q, lz_s;
    logic                  ovf_q, ovf_pend_q;
    logic [REF_W-1:0]      refresh_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            nib_s;
    logic                  dp_bit_s, blank_s;
    logic [6:0]            seg_s, seg_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  dp_q;

    // Converter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Converter next state: one step per cycle, DATA_W steps per conversion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load && bus.dec_mode) state_d = S_CONV;
                else                          state_d = S_IDLE;
            end
            S_CONV: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_IDLE;
                else                             state_d = S_CONV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Converter control decode; loads are only accepted while idle
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        last_s   = 1'b0;
        case (state_q)
            S_IDLE: accept_s = bus.load;
            S_CONV: begin
                step_s = 1'b1;
                last_s = (cnt_q == CNT_W'(DATA_W - 1));
            end
            default: accept_s = 1'b0;
        endcase
    end

    assign bus.busy = (state_q == S_CONV);

    // Datapath helpers: zero-extended hex value and next double-dabble step
    always_comb begin
        val_ext_s                = '0;
        val_ext_s[DATA_W-1:0]    = bus.value;
        bcd_next_s               = dd_step(bcd_q, sh_q[DATA_W-1]);
    end

    // Capture and conversion datapath; decimal result and dp mask commit together at the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            digit_q    <= '0;
            dpm_q      <= '0;
            dp_pend_q  <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (accept_s) begin
            if (bus.dec_mode) begin
                sh_q       <= bus.value;
                bcd_q      <= '0;
                cnt_q      <= '0;
                dp_pend_q  <= bus.dp_mask;
                ovf_pend_q <= (64'(bus.value) >= DEC_LIMIT);
            end else begin
                digit_q <= val_ext_s;
                dpm_q   <= bus.dp_mask;
                ovf_q   <= 1'b0;
            end
        end else if (step_s) begin
            sh_q  <= sh_q << 1;
            bcd_q <= bcd_next_s;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_s) begin
                digit_q <= bcd_next_s;
                dpm_q   <= dp_pend_q;
                ovf_q   <= ovf_pend_q;
            end
        end
    end

    // Refresh divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            refresh_q <= refresh_q + REF_W'(1);
        end
    end

`ifdef SSD_LZ_BLANK_EN
    // A digit is blanked when it and every digit above it are zero
    always_comb begin
        logic seen;
        seen = 1'b0;
        lz_s = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (digit_q[4*i +: 4] != 4'd0) seen = 1'b1;
            else                           seen = seen;
            lz_s[i] = ~seen;
        end
    end
`else
    assign lz_s = '0;
`endif

    // Select the current digit and encode it; dashes override blanking
    always_comb begin
        nib_s    = 4'(digit_q >> {idx_q, 2'b00});
        dp_bit_s = 1'(dpm_q >> idx_q);
        blank_s  = 1'(lz_s >> idx_q);
        if (ovf_q)        seg_s = SEG_DASH;
        else if (blank_s) seg_s = SEG_BLANK;
        else              seg_s = seg_encode(nib_s);
    end

    // Registered display drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= ~(NUM_DIGITS'(1) << idx_q);
            seg_q   <= seg_s;
            dp_q    <= ~dp_bit_s;
        end
    end

    assign bus.anode  = anode_q;
    assign bus.ssdOut = seg_q;
    assign bus.dp     = dp_q;
endmodule
